// File: rtl/data_memory_responder_if.sv
// Request/response bus between the core (master) and the data-memory responder (slave).
// Each channel transfers on a rising clock edge where valid && ready; the source holds
// the payload stable while valid is high and ready is low.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding load/store, LATENCY wait states, byte-lane stores.
// Optional macro DMEM_ALIGN_CHECK_EN: reject misaligned accesses instead of aligning them down.
module data_memory_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  data_memory_responder_if.slave     bus,
  output logic [1:0]                 dbg_state
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic [63:0] mem [DEPTH];

  logic        op_write;
  logic [1:0]  op_size;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  logic [63:0] size_mask;
  logic [2:0]  align_mask;
  logic [2:0]  lane;
  logic        range_err;
  logic        align_err;
  logic        acc_err;
  logic [IDXW-1:0] idx;
  logic [5:0]  shamt;
  logic [63:0] old_dw;
  logic [63:0] load_data;
  logic [63:0] store_dw;
  logic        accept;
  logic        commit;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state;

  assign accept = (state == IDLE) && bus.req_valid && req_ready_q;
  // With zero wait states the access completes on the accept edge itself.
  assign commit = (LATENCY == 0) ? accept : ((state == WAIT) && (cnt == 4'(LATENCY)));

  always_comb begin
    op_write = lat_write;
    op_size  = lat_size;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    if (state == IDLE) begin
      op_write = bus.req_write;
      op_size  = bus.req_size;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end
    size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
    align_mask = 3'b111;
    case (op_size)
      2'd0: begin size_mask = 64'h0000_0000_0000_00FF; align_mask = 3'b000; end
      2'd1: begin size_mask = 64'h0000_0000_0000_FFFF; align_mask = 3'b001; end
      2'd2: begin size_mask = 64'h0000_0000_FFFF_FFFF; align_mask = 3'b011; end
      default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; align_mask = 3'b111; end
    endcase
    range_err = op_addr[63:3] >= 61'(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    align_err = |(op_addr[2:0] & align_mask);
    lane      = op_addr[2:0];
`else
    align_err = 1'b0;
    lane      = op_addr[2:0] & ~align_mask;
`endif
    acc_err   = range_err || align_err;
    idx       = op_addr[3 +: IDXW];
    shamt     = {lane, 3'b000};
    old_dw    = range_err ? 64'd0 : mem[idx];
    load_data = (old_dw >> shamt) & size_mask;
    store_dw  = (old_dw & ~(size_mask << shamt)) | ((op_wdata << shamt) & (size_mask << shamt));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_write    <= 1'b0;
      lat_size     <= 2'd0;
      lat_addr     <= 64'd0;
      lat_wdata    <= 64'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write   <= bus.req_write;
            lat_size    <= bus.req_size;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            req_ready_q <= 1'b0;
            state       <= WAIT;
            cnt         <= 4'd1;
          end
        end
        WAIT: begin
          if (!commit) cnt <= cnt + 4'd1;
        end
        RESP: begin
          // Returning to IDLE raises req_ready, so the next accept is a cycle later.
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        state        <= RESP;
        cnt          <= 4'd0;
        resp_valid_q <= 1'b1;
        resp_err_q   <= acc_err;
        resp_rdata_q <= (acc_err || op_write) ? 64'd0 : load_data;
        if (!acc_err && op_write) mem[idx] <= store_dw;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed vector table, backpressure/reset/zero-latency
// sequences, then random traffic against a byte-array reference model.
module tb_data_memory_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state0;

  data_memory_responder_if bus ();
  data_memory_responder_if bus0 ();

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state(dbg_state0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_mem [DEPTH*8];

  typedef struct {
    bit          w;
    logic [1:0]  sz;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] rd;
    bit          err;
    int          hold;
    bit          intrude;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void ref_clear();
    for (int i = 0; i < DEPTH*8; i++) ref_mem[i] = 8'd0;
  endfunction

  // Byte-addressed little-endian memory; accesses are 1<<size bytes.
  function automatic void model(input bit w, input logic [1:0] sz, input logic [63:0] a,
                                input logic [63:0] wd, output logic [63:0] rd, output bit err);
    logic [63:0] n;
    logic [63:0] base;
    n    = 64'd1 << sz;
    err  = 1'b0;
    rd   = 64'd0;
    base = a;
    if (a / 8 >= 64'(DEPTH)) err = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % n != 0) err = 1'b1;
`else
    base = a - (a % n);
`endif
    if (!err) begin
      for (int i = 0; i < int'(n); i++) begin
        if (w) ref_mem[int'(base) + i] = wd[8*i +: 8];
        else   rd[8*i +: 8] = ref_mem[int'(base) + i];
      end
    end
  endfunction

  // Starts and ends at a negedge with the responder expected idle.
  task automatic txn(input bit w, input logic [1:0] sz, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] ex_rd, input bit ex_err,
                     input int hold, input bit intrude, input string tag);
    int lat;
    check({tag, " req_ready before"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_size  = 2'($urandom_range(0, 3));
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 40);
    check({tag, " latency"}, 64'(lat), 64'(LAT + 1));
    check({tag, " rdata"}, bus.resp_rdata, ex_rd);
    check({tag, " err"}, 64'(bus.resp_err), 64'(ex_err));
    if (intrude) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'd3;
      bus.req_addr  = 64'h10;
      bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, " hold rdata"}, bus.resp_rdata, ex_rd);
      check({tag, " hold req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    @(negedge clk);
    check({tag, " valid after hs"}, 64'(bus.resp_valid), 64'd0);
    check({tag, " ready after hs"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic txn0(input bit w, input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] ex_rd, input string tag);
    int lat;
    bus0.req_valid = 1'b1;
    bus0.req_write = w;
    bus0.req_size  = 2'd3;
    bus0.req_addr  = a;
    bus0.req_wdata = wd;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus0.resp_valid && lat < 20);
    check({tag, " latency"}, 64'(lat), 64'd1);
    check({tag, " rdata"}, bus0.resp_rdata, ex_rd);
    check({tag, " err"}, 64'(bus0.resp_err), 64'd0);
    bus0.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.resp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m_rd;
    bit          m_err;
    bit          w;
    logic [1:0]  sz;
    logic [63:0] a;
    logic [63:0] wd;

    reset = 1'b0;
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_size  = 2'd0;
    bus.req_addr   = 64'd0; bus.req_wdata = 64'd0; bus.resp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'd0;
    bus0.req_addr  = 64'd0; bus0.req_wdata = 64'd0; bus0.resp_ready = 1'b0;
    ref_clear();

    repeat (3) @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset resp_rdata", bus.resp_rdata, 64'd0);
    check("reset resp_err", 64'(bus.resp_err), 64'd0);
    check("reset dbg_state", 64'(dbg_state), 64'd0);
    check("reset dbg_state0", 64'(dbg_state0), 64'd0);
    check("reset req_ready0", 64'(bus0.req_ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);

    tbl[0]  = '{1'b1, 2'd3, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, 2'd3, 64'h10, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0, 1, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 64'h10, 64'h0, 64'h1122_3344_AB66_7788, 1'b0, 0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 64'h13, 64'h0, 64'h0000_0000_0000_00AB, 1'b0, 0, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 64'h12, 64'h0, 64'h0000_0000_0000_AB66, 1'b0, 5, 1'b1};
    tbl[6]  = '{1'b0, 2'd3, 64'h10, 64'h0, 64'h1122_3344_AB66_7788, 1'b0, 0, 1'b0};
    tbl[7]  = '{1'b0, 2'd3, 64'(DEPTH*8), 64'h0, 64'h0, 1'b1, 0, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 64'(DEPTH*8), 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, 1'b0};
    tbl[9]  = '{1'b0, 2'd3, 64'h0, 64'h0, 64'h0, 1'b0, 0, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    tbl[10] = '{1'b1, 2'd2, 64'h22, 64'hDEAD_BEEF, 64'h0, 1'b1, 0, 1'b0};
    tbl[11] = '{1'b0, 2'd3, 64'h20, 64'h0, 64'h0, 1'b0, 0, 1'b0};
    tbl[16] = '{1'b0, 2'd2, 64'h16, 64'h0, 64'h0, 1'b1, 0, 1'b0};
`else
    tbl[10] = '{1'b1, 2'd2, 64'h22, 64'hDEAD_BEEF, 64'h0, 1'b0, 0, 1'b0};
    tbl[11] = '{1'b0, 2'd3, 64'h20, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, 0, 1'b0};
    tbl[16] = '{1'b0, 2'd2, 64'h16, 64'h0, 64'h0000_0000_1122_3344, 1'b0, 0, 1'b0};
`endif
    tbl[12] = '{1'b1, 2'd3, 64'((DEPTH-1)*8), 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0, 0, 1'b0};
    tbl[13] = '{1'b0, 2'd3, 64'((DEPTH-1)*8), 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0, 0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 64'h8000_0000_0000_0010, 64'h0, 64'h0, 1'b1, 0, 1'b0};
    tbl[15] = '{1'b0, 2'd2, 64'h14, 64'h0, 64'h0000_0000_1122_3344, 1'b0, 0, 1'b0};

    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, m_rd, m_err);
      txn(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err,
          tbl[i].hold, tbl[i].intrude, $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 150; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, DEPTH*8 + 15));
      wd = {$urandom, $urandom};
      model(w, sz, a, wd, m_rd, m_err);
      txn(w, sz, a, wd, m_rd, m_err, $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during WAIT: a nonzero load result is still registered when the store is aborted.
    model(1'b1, 2'd3, 64'h10, 64'h0102_0304_0506_0708, m_rd, m_err);
    txn(1'b1, 2'd3, 64'h10, 64'h0102_0304_0506_0708, 64'h0, 1'b0, 0, 1'b0, "pre_rst_st");
    txn(1'b0, 2'd3, 64'h10, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 0, 1'b0, "pre_rst_ld");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd3;
    bus.req_addr  = 64'h40;
    bus.req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_wait resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_wait resp_rdata", bus.resp_rdata, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ref_clear();
    @(negedge clk);
    txn(1'b0, 2'd3, 64'h40, 64'h0, 64'h0, 1'b0, 0, 1'b0, "rst_aborted_store");
    txn(1'b0, 2'd3, 64'h10, 64'h0, 64'h0, 1'b0, 0, 1'b0, "rst_cleared_mem");

    txn0(1'b1, 64'h10, 64'h1122_3344_5566_7788, 64'h0, "lat0_store");
    txn0(1'b0, 64'h10, 64'h0, 64'h1122_3344_5566_7788, "lat0_load");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
